uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
- REQ-001 SHALL have parameter DATA_W, default 8, meaning the number of data bits per frame; only the value 8 is supported.
- REQ-002 SHALL have parameter BAUD_W, default 16, meaning the width of the baud divisor.
- REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock.
- REQ-004 SHALL have port sys_rstn, input, 1 bit: reset, asynchronous, active-low.
- REQ-005 SHALL have port uart_rx, input, 1 bit: serial line, idle high, asynchronous to sys_clk.
- REQ-006 SHALL have port uart_en, input, 1 bit: receiver enable, from the uart_con bit 0 decode.
- REQ-007 SHALL have port uart_baud, input, 16 bits: bit period equals uart_baud+1 sys_clk cycles.
- REQ-008 SHALL have port uart_rxbuf_rd, input, 1 bit: single-cycle read strobe that clears the status flags.
- REQ-009 SHALL have port uart_rxbuf, output, 16 bits: [7:0] data, [8] done, [9] framing error, [10] overrun, [11] parity error, [15:12] zero.
- REQ-010 SHALL have port uart_rx_int, output, 1 bit: level interrupt equal to uart_rxbuf[8].

Function
- REQ-011 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value.
- REQ-012 SHALL treat uart_baud values below 3 as 3.
- REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
- REQ-014 IDLE->START SHALL occur on a synchronized 1->0 edge while uart_en=1, with the bit counter cleared.
- REQ-015 In START, after (uart_baud>>1)+1 cycles, the FSM SHALL sample the line: if low, go to DATA; if high, treat as a glitch, return to IDLE, and leave the flags untouched.
- REQ-016 DATA SHALL sample every uart_baud+1 cycles and shift LSB first; after 8 bits it SHALL go to PARITY if that is compiled in, otherwise to STOP.
- REQ-017 STOP SHALL sample the line once, after which the FSM SHALL return to IDLE.
- REQ-018 One cycle after the stop sample, [7:0] SHALL load the data and done SHALL set.
- REQ-019 If the stop sample is 0, the receiver SHALL set the framing-error flag and still load the data.
- REQ-020 If done is already 1 when a frame completes, the new data SHALL overwrite [7:0] and the overrun flag SHALL set.
- REQ-021 uart_rxbuf_rd SHALL clear done, framing error, overrun and parity error on the next edge; [7:0] SHALL hold.
- REQ-022 If uart_rxbuf_rd coincides with a frame completion, the completion SHALL win: done stays 1 and overrun is not set.
- REQ-023 uart_en=0 SHALL force IDLE and clear the counters within 1 cycle; a partial frame SHALL be discarded; the flags and data SHALL be retained.
- REQ-024 A new start edge SHALL be accepted in the cycle after the STOP->IDLE transition, allowing back-to-back frames.

Reset
- REQ-025 While sys_rstn=0, the block SHALL hold: state IDLE, all counters 0, uart_rxbuf=16'h0000, uart_rx_int=0, synchronizer flops =1.
- REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; no flag SHALL be set after release.

Configuration
- REQ-027 UART_RX_PARITY_EN defined: the PARITY state SHALL sample one bit after the data bits; even parity SHALL be assumed; a mismatch SHALL set [11].
- REQ-028 UART_RX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and [11] SHALL be constant 0.

Structure
- REQ-029 Shared package uart_pkg SHALL hold: the FSM state encoding, the uart_rxbuf bit-index constants, and the minimum-divisor constant 3.
- REQ-030 The bit-period counter SHALL be one sub-module, uart_rx_baudgen, with inputs clear and divisor, and outputs half_tick and full_tick.

Verification
- REQ-031 Scenario: uart_baud=15, uart_en=1, frame 0x3A with a good stop -> uart_rxbuf=16'h013A, uart_rx_int=1; a read pulse then gives 16'h003A.
- REQ-032 Scenario: line low for 4 cycles, then high, with uart_baud=15 -> state returns to IDLE and uart_rxbuf is unchanged.
- REQ-033 Scenario: frame 0x55 with stop=0 -> uart_rxbuf=16'h0355.
- REQ-034 Scenario: frames 0x11 then 0x22 with no read -> uart_rxbuf=16'h0522; a read strobe coinciding with a third frame 0x33 -> 16'h0133.
- REQ-035 Scenario: sys_rstn dropped at data bit 4, or uart_en dropped at data bit 4 -> no flag set; next frame 0xA5 -> 16'h01A5.
- REQ-036 Scenario: with UART_RX_PARITY_EN, frame 0x07 with a parity bit of 0 -> uart_rxbuf=16'h0907.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, receive-buffer bit positions and divisor floor for the UART receiver
// Contents:
//   rx_state_e  - receiver FSM state encoding
//   RXB_*       - bit positions of the status flags inside uart_rxbuf
//   MIN_DIV     - smallest usable baud divisor; smaller programmed values are raised to this
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int RXB_DONE = 8;
  localparam int RXB_FE   = 9;
  localparam int RXB_OVR  = 10;
  localparam int RXB_PE   = 11;

  localparam int MIN_DIV = 3;

endpackage

// File: rtl/uart_rx_baudgen.sv
// uart_rx_baudgen: bit-period counter producing mid-bit and end-of-bit ticks
// Ports:
//   sys_clk, sys_rstn - clock and asynchronous active-low reset
//   clear             - hold the counter at zero (restarts the bit period)
//   divisor           - bit period is divisor+1 cycles
//   half_tick         - counter has reached divisor>>1 (mid start bit)
//   full_tick         - counter has reached divisor (one full bit period elapsed)
module uart_rx_baudgen #(
  parameter int BAUD_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              clear,
  input  logic [BAUD_W-1:0] divisor,
  output logic              half_tick,
  output logic              full_tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a divisor lowered mid-frame cannot strand the counter
  always_comb begin
    half_tick = cnt_q == (divisor >> 1);
    full_tick = cnt_q >= divisor;
    cnt_d     = (clear || full_tick) ? '0 : cnt_q + BAUD_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with status flags and optional even parity (UART_RX_PARITY_EN)
// Ports:
//   sys_clk, sys_rstn - clock and asynchronous active-low reset
//   uart_rx           - serial line, idle high, asynchronous to sys_clk
//   uart_en           - receiver enable; low aborts any frame in progress
//   uart_baud         - bit period is uart_baud+1 cycles (values below 3 act as 3)
//   uart_rxbuf_rd     - one-cycle strobe clearing done/framing/overrun/parity flags
//   uart_rxbuf        - {4'b0, parity err, overrun, framing err, done, data[7:0]}
//   uart_rx_int       - level interrupt, mirrors the done flag
// Build option: define UART_RX_PARITY_EN to receive an even-parity bit after the data bits.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              uart_rx,
  input  logic              uart_en,
  input  logic [BAUD_W-1:0] uart_baud,
  input  logic              uart_rxbuf_rd,
  output logic [15:0]       uart_rxbuf,
  output logic              uart_rx_int
);

  localparam int BC_W = $clog2(DATA_W);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  rx_state_e         state_q, state_d;
  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cmp_q, cmp_d, cmp_fe_q, cmp_fe_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d, fe_q, fe_d, ovr_q, ovr_d;
  logic              pe_flag;
  logic [BAUD_W-1:0] div;
  logic              rx, fall, half_tick, full_tick;
  logic              baud_clear, shift_en, stop_smp;
`ifdef UART_RX_PARITY_EN
  logic              pbit_q, pbit_d, pe_q, pe_d, par_smp;
`endif

  assign rx   = rx_s2_q;
  assign fall = rx_prev_q & ~rx_s2_q;
  assign div  = (uart_baud < BAUD_W'(MIN_DIV)) ? BAUD_W'(MIN_DIV) : uart_baud;

  uart_rx_baudgen #(.BAUD_W(BAUD_W)) u_baudgen (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .clear     (baud_clear),
    .divisor   (div),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = fall ? ST_START : ST_IDLE;
      ST_START:  state_d = !half_tick ? ST_START : rx ? ST_IDLE : ST_DATA;
      ST_DATA:   state_d = (full_tick && bit_cnt_q == BC_W'(DATA_W - 1)) ? AFTER_DATA : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: state_d = full_tick ? ST_STOP : ST_PARITY;
`endif
      ST_STOP:   state_d = full_tick ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
    if (!uart_en) state_d = ST_IDLE;
  end

  // Counter restarts on leaving START so DATA samples land mid-bit
  always_comb begin
    baud_clear = !uart_en || state_q == ST_IDLE || (state_q == ST_START && half_tick);
    shift_en   = uart_en && state_q == ST_DATA && full_tick;
    stop_smp   = uart_en && state_q == ST_STOP && full_tick;
`ifdef UART_RX_PARITY_EN
    par_smp    = uart_en && state_q == ST_PARITY && full_tick;
`endif
  end

  // Completion is registered (cmp_q) so the buffer updates one cycle after the stop sample;
  // a coincident read loses to the completion, and overrun only arises without a read.
  always_comb begin
    rx_s1_d   = uart_rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    bit_cnt_d = (!uart_en || state_q == ST_IDLE) ? '0 : shift_en ? bit_cnt_q + BC_W'(1) : bit_cnt_q;
    shreg_d   = shift_en ? {rx, shreg_q[DATA_W-1:1]} : shreg_q;
    cmp_d     = stop_smp;
    cmp_fe_d  = stop_smp & ~rx;
    data_d    = cmp_q ? shreg_q : data_q;
    done_d    = cmp_q | (done_q & ~uart_rxbuf_rd);
    fe_d      = (fe_q & ~uart_rxbuf_rd) | (cmp_q & cmp_fe_q);
    ovr_d     = ~uart_rxbuf_rd & (ovr_q | (cmp_q & done_q));
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones
  always_comb begin
    pbit_d = par_smp ? rx : pbit_q;
    pe_d   = (pe_q & ~uart_rxbuf_rd) | (cmp_q & (^shreg_q ^ pbit_q));
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pbit_q <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      pbit_q <= pbit_d;
      pe_q   <= pe_d;
    end
  end

  assign pe_flag = pe_q;
`else
  assign pe_flag = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      cmp_q     <= 1'b0;
      cmp_fe_q  <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      cmp_q     <= cmp_d;
      cmp_fe_q  <= cmp_fe_d;
      data_q    <= data_d;
      done_q    <= done_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    uart_rxbuf           = '0;
    uart_rxbuf[7:0]      = data_q;
    uart_rxbuf[RXB_DONE] = done_q;
    uart_rxbuf[RXB_FE]   = fe_q;
    uart_rxbuf[RXB_OVR]  = ovr_q;
    uart_rxbuf[RXB_PE]   = pe_flag;
    uart_rx_int          = done_q;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames checked every cycle against a frame-level model plus literal expectations
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ev_t;

  logic        sys_clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_en = 1'b0;
  logic [15:0] uart_baud = 16'd15;
  logic        uart_rxbuf_rd = 1'b0;
  logic [15:0] uart_rxbuf;
  logic        uart_rx_int;

  ev_t         push_buf[64];
  int          push_n = 0;
  ev_t         evq[$];
  int          taken = 0;
  int          cyc = 0;
  logic [7:0]  m_data = '0;
  logic        m_done = 1'b0, m_fe = 1'b0, m_ovr = 1'b0, m_pe = 1'b0;

  logic [15:0] lit_exp = '0;
  string       lit_name = "";
  int          lit_seq = 0, lit_seen = 0;
  int          n_checks = 0, n_fail = 0;
  int          t_rd;

  always #5 sys_clk = ~sys_clk;

  uart_rx_core dut (
    .sys_clk       (sys_clk),
    .sys_rstn      (sys_rstn),
    .uart_rx       (uart_rx),
    .uart_en       (uart_en),
    .uart_baud     (uart_baud),
    .uart_rxbuf_rd (uart_rxbuf_rd),
    .uart_rxbuf    (uart_rxbuf),
    .uart_rx_int   (uart_rx_int)
  );

  // Edge index at which a frame whose start bit begins at the current negedge updates the buffer:
  // 2 sync stages + 1 edge-detect cycle + half a bit + NB full bits + 1 cycle to load.
  function automatic int frame_done_cyc();
    int div;
    div = (uart_baud < 16'd3) ? 3 : int'(uart_baud);
    return cyc + 1 + 4 + div / 2 + NB * (div + 1);
  endfunction

  // Frame-level model: applies queued frame results at their due edge, reads, enable drop and reset
  always @(posedge sys_clk) begin
    ev_t e;
    cyc++;
    while (taken < push_n) begin
      evq.push_back(push_buf[taken]);
      taken++;
    end
    if (!sys_rstn) begin
      m_data = '0;
      m_done = 1'b0;
      m_fe   = 1'b0;
      m_ovr  = 1'b0;
      m_pe   = 1'b0;
      evq.delete();
    end else begin
      if (!uart_en)
        while (evq.size() > 0 && evq[evq.size()-1].c > cyc) void'(evq.pop_back());
      if (evq.size() > 0 && evq[0].c == cyc) begin
        e = evq.pop_front();
        if (uart_rxbuf_rd) begin
          m_fe  = e.fe;
          m_ovr = 1'b0;
          m_pe  = e.pe;
        end else begin
          m_ovr = m_ovr | m_done;
          m_fe  = m_fe | e.fe;
          m_pe  = m_pe | e.pe;
        end
        m_done = 1'b1;
        m_data = e.d;
      end else if (uart_rxbuf_rd) begin
        m_done = 1'b0;
        m_fe   = 1'b0;
        m_ovr  = 1'b0;
        m_pe   = 1'b0;
      end
    end
  end

  always @(posedge sys_clk) begin
    #1;
    n_checks++;
    if (uart_rxbuf !== {4'h0, m_pe, m_ovr, m_fe, m_done, m_data} || uart_rx_int !== m_done) begin
      n_fail++;
      $display("FAIL model cyc=%0d: rxbuf=%h int=%b, expected rxbuf=%h int=%b",
               cyc, uart_rxbuf, uart_rx_int, {4'h0, m_pe, m_ovr, m_fe, m_done, m_data}, m_done);
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_checks++;
      if (uart_rxbuf !== lit_exp || uart_rx_int !== lit_exp[8]) begin
        n_fail++;
        $display("FAIL %s: rxbuf=%h int=%b, expected rxbuf=%h int=%b",
                 lit_name, uart_rxbuf, uart_rx_int, lit_exp, lit_exp[8]);
      end
    end
  end

  task automatic expect_lit(input logic [15:0] v, input string nm);
    lit_exp  = v;
    lit_name = nm;
    lit_seq++;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic read_buf();
    uart_rxbuf_rd = 1'b1;
    @(negedge sys_clk);
    uart_rxbuf_rd = 1'b0;
  endtask

  // Called on a negedge; abort 1 drops reset and abort 2 drops enable at the start of data bit 4
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit, input int abort);
    logic [10:0] bits;
    logic        pe;
    int          div;
    div = (uart_baud < 16'd3) ? 3 : int'(uart_baud);
`ifdef UART_RX_PARITY_EN
    bits = {stop, pbit, d, 1'b0};
    pe   = ^{d, pbit};
`else
    bits = {1'b1, stop, d, 1'b0};
    pe   = 1'b0;
`endif
    push_buf[push_n] = '{c: frame_done_cyc(), d: d, fe: ~stop, pe: pe};
    push_n++;
    for (int i = 0; i <= NB; i++) begin
      uart_rx = bits[i];
      if (abort == 1 && i == 5) sys_rstn = 1'b0;
      if (abort == 2 && i == 5) uart_en = 1'b0;
      repeat (div + 1) @(negedge sys_clk);
    end
    uart_rx = 1'b1;
    if (abort != 0) begin
      sys_rstn = 1'b1;
      uart_en  = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    expect_lit(16'h0000, "reset");
    sys_rstn = 1'b1;
    uart_en  = 1'b1;
    idle(4);
    expect_lit(16'h0000, "after_reset");

    send_frame(8'h3A, 1'b1, ^(8'h3A), 0);
    idle(8);
    expect_lit(16'h013A, "frame_3a");
    read_buf();
    expect_lit(16'h003A, "read_3a");

    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
    expect_lit(16'h003A, "glitch");

    send_frame(8'h55, 1'b0, ^(8'h55), 0);
    idle(8);
    expect_lit(16'h0355, "framing_55");
    read_buf();
    expect_lit(16'h0055, "read_55");

    send_frame(8'h11, 1'b1, ^(8'h11), 0);
    send_frame(8'h22, 1'b1, ^(8'h22), 0);
    idle(8);
    expect_lit(16'h0522, "overrun_22");

    t_rd = frame_done_cyc();
    fork
      send_frame(8'h33, 1'b1, ^(8'h33), 0);
      begin
        while (cyc < t_rd - 1) @(negedge sys_clk);
        uart_rxbuf_rd = 1'b1;
        @(negedge sys_clk);
        uart_rxbuf_rd = 1'b0;
      end
    join
    idle(8);
    expect_lit(16'h0133, "read_vs_done_33");
    read_buf();

    send_frame(8'hA5, 1'b1, ^(8'hA5), 1);
    idle(8);
    expect_lit(16'h0000, "reset_abort");
    send_frame(8'hA5, 1'b1, ^(8'hA5), 0);
    idle(8);
    expect_lit(16'h01A5, "after_reset_a5");
    read_buf();
    send_frame(8'h3C, 1'b1, ^(8'h3C), 2);
    idle(8);
    expect_lit(16'h00A5, "en_abort");
    send_frame(8'hA5, 1'b1, ^(8'hA5), 0);
    idle(8);
    expect_lit(16'h01A5, "after_en_a5");
    read_buf();

    uart_baud = 16'd1;
    idle(2);
    send_frame(8'hC3, 1'b1, ^(8'hC3), 0);
    idle(8);
    expect_lit(16'h01C3, "baud1_c3");
    read_buf();
    uart_baud = 16'd0;
    idle(2);
    send_frame(8'h96, 1'b1, ^(8'h96), 0);
    idle(8);
    expect_lit(16'h0196, "baud0_96");
    read_buf();
    uart_baud = 16'd3;
    idle(2);
    send_frame(8'h81, 1'b1, ^(8'h81), 0);
    idle(8);
    expect_lit(16'h0181, "baud3_81");
    read_buf();

`ifdef UART_RX_PARITY_EN
    uart_baud = 16'd15;
    idle(2);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(8);
    expect_lit(16'h0907, "parity_err_07");
    read_buf();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(8);
    expect_lit(16'h0107, "parity_ok_07");
    read_buf();
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
